// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file bus: read ports, write port and flag capture/readback
//
// master : drives addresses, write data/enable and ALU flag inputs; receives read data and flags
// slave  : the register file side
interface reg_file_if #(
    parameter int W = 8,
    parameter int A = 3
);
    logic [A-1:0] RdAddrA;
    logic [A-1:0] RdAddrB;
    logic [W-1:0] DatA;
    logic [W-1:0] DatB;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrDat;
    logic         FlagEn;
    logic         ZeroIn;
    logic         ParIn;
    logic         SCoIn;
    logic         ZeroQ;
    logic         ParQ;
    logic         SCoQ;

    modport master (
        output RdAddrA, RdAddrB, WrEn, WrAddr, WrDat, FlagEn, ZeroIn, ParIn, SCoIn,
        input  DatA, DatB, ZeroQ, ParQ, SCoQ
    );

    modport slave (
        input  RdAddrA, RdAddrB, WrEn, WrAddr, WrDat, FlagEn, ZeroIn, ParIn, SCoIn,
        output DatA, DatB, ZeroQ, ParQ, SCoQ
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**A x W register file with two async read ports, one write port and a 3-bit flag register
//
// Ports:
//   Clk    - clock, all state updates on the rising edge
//   Reset  - synchronous active-low reset; clears every register and all flags
//   bus    - reg_file_if slave modport:
//            RdAddrA/RdAddrB -> DatA/DatB  combinational reads (optional same-cycle write forwarding)
//            WrEn/WrAddr/WrDat             synchronous write port
//            FlagEn/ZeroIn/ParIn/SCoIn     flag capture, independent of the write port
//            ZeroQ/ParQ/SCoQ               registered flags
module reg_file #(
    parameter int W      = 8,
    parameter int A      = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** A;

    logic [W-1:0] mem [DEPTH];
    logic [2:0]   flags;
    logic         hit_a;
    logic         hit_b;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            flags <= 3'b000;
        end else begin
            if (bus.WrEn) begin
                mem[bus.WrAddr] <= bus.WrDat;
            end
            if (bus.FlagEn) begin
                flags <= {bus.ZeroIn, bus.ParIn, bus.SCoIn};
            end
        end
    end

    // Forwarding is suppressed during reset so a write that reset will drop
    // never shows up on the operand buses.
    assign hit_a = BYPASS && Reset && bus.WrEn && (bus.WrAddr == bus.RdAddrA);
    assign hit_b = BYPASS && Reset && bus.WrEn && (bus.WrAddr == bus.RdAddrB);

    assign bus.DatA = hit_a ? bus.WrDat : mem[bus.RdAddrA];
    assign bus.DatB = hit_b ? bus.WrDat : mem[bus.RdAddrB];

    assign bus.ZeroQ = flags[2];
    assign bus.ParQ  = flags[1];
    assign bus.SCoQ  = flags[0];
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file, bypass and non-bypass builds side by side
module tb_reg_file;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       we, fe;
    logic [2:0] wa, ra, rb, fin;
    logic [7:0] wd;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    reg_file_if #(.W(8), .A(3)) bus_b ();
    reg_file_if #(.W(8), .A(3)) bus_n ();

    assign bus_b.RdAddrA = ra;  assign bus_n.RdAddrA = ra;
    assign bus_b.RdAddrB = rb;  assign bus_n.RdAddrB = rb;
    assign bus_b.WrEn    = we;  assign bus_n.WrEn    = we;
    assign bus_b.WrAddr  = wa;  assign bus_n.WrAddr  = wa;
    assign bus_b.WrDat   = wd;  assign bus_n.WrDat   = wd;
    assign bus_b.FlagEn  = fe;  assign bus_n.FlagEn  = fe;
    assign bus_b.ZeroIn  = fin[2];  assign bus_n.ZeroIn = fin[2];
    assign bus_b.ParIn   = fin[1];  assign bus_n.ParIn  = fin[1];
    assign bus_b.SCoIn   = fin[0];  assign bus_n.SCoIn  = fin[0];

    reg_file #(.W(8), .A(3), .BYPASS(1'b1)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b.slave));
    reg_file #(.W(8), .A(3), .BYPASS(1'b0)) dut_n (.Clk(Clk), .Reset(Reset), .bus(bus_n.slave));

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra, rb;
        logic       fe;
        logic [2:0] fin;
        logic [7:0] pa_b, pa_n, pb_b, pb_n;  // before the edge
        logic [7:0] qa, qb;                  // after the edge, both builds
        logic [2:0] qf;
    } vec_t;

    vec_t vt[11];

    // reference model state
    logic [7:0] mdl [8];
    logic [2:0] mflags;

    function automatic vec_t mk(logic w, logic [2:0] a, logic [7:0] d, logic [2:0] r1, logic [2:0] r2,
                                logic f, logic [2:0] fi, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3,
                                logic [7:0] p4, logic [7:0] q1, logic [7:0] q2, logic [2:0] qfl);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.ra = r1; v.rb = r2; v.fe = f; v.fin = fi;
        v.pa_b = p1; v.pa_n = p2; v.pb_b = p3; v.pb_n = p4; v.qa = q1; v.qb = q2; v.qf = qfl;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; fe = 1'b0; fin = '0;
    endtask

    function automatic logic [2:0] flags_of_b();
        return {bus_b.ZeroQ, bus_b.ParQ, bus_b.SCoQ};
    endfunction

    function automatic logic [2:0] flags_of_n();
        return {bus_n.ZeroQ, bus_n.ParQ, bus_n.SCoQ};
    endfunction

    initial begin
        Reset = 1'b0; ra = '0; rb = '0;
        idle();
        step();
        Reset = 1'b1;

        // reset state
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(7 - i); #1;
            check("init_a_byp", bus_b.DatA, 8'h00);
            check("init_b_nob", bus_n.DatB, 8'h00);
        end
        check("init_flags", {5'b0, flags_of_b()}, 8'h00);

        // fill with FF, then one reset edge clears everything
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); wd = 8'hFF; fe = 1'b1; fin = 3'b111;
            step();
        end
        idle();
        ra = 3'd5; rb = 3'd0; #1;
        check("ff_fill_byp", bus_b.DatA, 8'hFF);
        check("ff_fill_nob", bus_n.DatB, 8'hFF);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(i); #1;
            check("rst_a_byp", bus_b.DatA, 8'h00);
            check("rst_b_nob", bus_n.DatB, 8'h00);
        end
        check("rst_flags_byp", {5'b0, flags_of_b()}, 8'h00);
        check("rst_flags_nob", {5'b0, flags_of_n()}, 8'h00);

        // directed vectors starting from an all-zero file
        vt[0]  = mk(1, 3, 8'h5A, 0, 0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
        vt[1]  = mk(1, 6, 8'hA5, 3, 6, 0, 3'b000, 8'h5A, 8'h5A, 8'hA5, 8'h00, 8'h5A, 8'hA5, 3'b000);
        vt[2]  = mk(0, 0, 8'h00, 3, 3, 0, 3'b000, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 3'b000);
        vt[3]  = mk(1, 2, 8'h11, 0, 0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
        vt[4]  = mk(1, 2, 8'h22, 2, 3, 0, 3'b000, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'h22, 8'h5A, 3'b000);
        vt[5]  = mk(0, 0, 8'h00, 2, 6, 1, 3'b101, 8'h22, 8'h22, 8'hA5, 8'hA5, 8'h22, 8'hA5, 3'b101);
        vt[6]  = mk(0, 0, 8'h00, 2, 6, 0, 3'b010, 8'h22, 8'h22, 8'hA5, 8'hA5, 8'h22, 8'hA5, 3'b101);
        vt[7]  = mk(0, 0, 8'h00, 2, 6, 0, 3'b010, 8'h22, 8'h22, 8'hA5, 8'hA5, 8'h22, 8'hA5, 3'b101);
        vt[8]  = mk(0, 0, 8'h00, 2, 6, 0, 3'b010, 8'h22, 8'h22, 8'hA5, 8'hA5, 8'h22, 8'hA5, 3'b101);
        vt[9]  = mk(0, 0, 8'h00, 3, 6, 1, 3'b011, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 3'b011);
        vt[10] = mk(1, 7, 8'hC3, 7, 7, 0, 3'b100, 8'hC3, 8'h00, 8'hC3, 8'h00, 8'hC3, 8'hC3, 3'b011);

        for (int i = 0; i < 11; i++) begin
            we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            ra = vt[i].ra; rb = vt[i].rb; fe = vt[i].fe; fin = vt[i].fin;
            #1;
            check($sformatf("v%0d_pre_a_byp", i), bus_b.DatA, vt[i].pa_b);
            check($sformatf("v%0d_pre_a_nob", i), bus_n.DatA, vt[i].pa_n);
            check($sformatf("v%0d_pre_b_byp", i), bus_b.DatB, vt[i].pb_b);
            check($sformatf("v%0d_pre_b_nob", i), bus_n.DatB, vt[i].pb_n);
            step();
            idle();
            #1;
            check($sformatf("v%0d_post_a_byp", i), bus_b.DatA, vt[i].qa);
            check($sformatf("v%0d_post_a_nob", i), bus_n.DatA, vt[i].qa);
            check($sformatf("v%0d_post_b_byp", i), bus_b.DatB, vt[i].qb);
            check($sformatf("v%0d_post_b_nob", i), bus_n.DatB, vt[i].qb);
            check($sformatf("v%0d_flags_byp", i), {5'b0, flags_of_b()}, {5'b0, vt[i].qf});
            check($sformatf("v%0d_flags_nob", i), {5'b0, flags_of_n()}, {5'b0, vt[i].qf});
        end

        // reset dominates a concurrent write, and forwarding is gated during reset
        we = 1'b1; wa = 3'd1; wd = 8'h33; ra = 3'd1; rb = 3'd1;
        step();
        idle();
        Reset = 1'b0; we = 1'b1; wa = 3'd1; wd = 8'h44; fe = 1'b1; fin = 3'b111;
        #1;
        check("rstpri_pre_byp", bus_b.DatA, 8'h33);
        check("rstpri_pre_nob", bus_n.DatA, 8'h33);
        step();
        Reset = 1'b1;
        idle();
        #1;
        check("rstpri_post_byp", bus_b.DatA, 8'h00);
        check("rstpri_post_nob", bus_n.DatB, 8'h00);
        check("rstpri_flags", {5'b0, flags_of_b()}, 8'h00);

        // randomized run against an array model of the architectural state
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        mflags = 3'b000;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ea_b, eb_b;
            Reset = ($urandom_range(0, 19) != 0);
            we  = $urandom_range(0, 1) == 1;
            fe  = $urandom_range(0, 2) == 0;
            wa  = 3'($urandom);
            wd  = 8'($urandom);
            fin = 3'($urandom);
            ra  = ($urandom_range(0, 1) == 1) ? wa : 3'($urandom);
            rb  = 3'($urandom);
            #1;
            ea_b = (Reset && we && wa == ra) ? wd : mdl[ra];
            eb_b = (Reset && we && wa == rb) ? wd : mdl[rb];
            check("rnd_a_byp", bus_b.DatA, ea_b);
            check("rnd_b_byp", bus_b.DatB, eb_b);
            check("rnd_a_nob", bus_n.DatA, mdl[ra]);
            check("rnd_b_nob", bus_n.DatB, mdl[rb]);
            step();
            if (!Reset) begin
                for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
                mflags = 3'b000;
            end else begin
                if (we) mdl[wa] = wd;
                if (fe) mflags = fin;
            end
            check("rnd_flags_byp", {5'b0, flags_of_b()}, {5'b0, mflags});
            check("rnd_flags_nob", {5'b0, flags_of_n()}, {5'b0, mflags});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file and flag register sitting directly upstream of the ALU. Two combinational read ports drive the ALU operand inputs `DatA`/`DatB`. One synchronous write port accepts the writeback result. A 3-bit flag register captures the ALU's `Zero`, `Par` and `SCo` outputs for use by branch and shift logic.

## Interface
- `W`, 8 — data width; matches the ALU datapath.
- `A`, 3 — address width; depth = 2**A registers.
- `BYPASS`, 1 — 1: write-to-read forwarding enabled; 0: reads return stored value only.

- `Clk`  in  1  — clock; all state updates on rising edge.
- `Reset`  in  1  — one clock; reset is synchronous and active-low; reset asserted when `Reset`=0 at a rising edge of `Clk`.
- `RdAddrA`  in  A  — read port A address.
- `RdAddrB`  in  A  — read port B address.
- `DatA`  out  W  — port A data; connects to ALU `DatA`.
- `DatB`  out  W  — port B data; connects to ALU `DatB`.
- `WrEn`  in  1  — write enable.
- `WrAddr`  in  A  — write address.
- `WrDat`  in  W  — write data; normally ALU `Rslt` or load data.
- `FlagEn`  in  1  — flag capture enable.
- `ZeroIn`, `ParIn`, `SCoIn`  in  1 each — ALU flag outputs.
- `ZeroQ`, `ParQ`, `SCoQ`  out  1 each — registered flags.

## Operation
- Storage: 2**A registers of W bits, plus a 3-bit flag register. No register is hardwired; R0 is an ordinary register.
- Reads: combinational, asynchronous to `Clk`.
  - `DatA` = mem[`RdAddrA`]; `DatB` = mem[`RdAddrB`].
  - Both ports may address the same register in the same cycle; both return identical data.
- Write: at rising edge, if `Reset`=1 and `WrEn`=1, mem[`WrAddr`] <= `WrDat`. With `WrEn`=0, no register changes.
- Bypass, `BYPASS`=1 only:
  - If `WrEn`=1 and `WrAddr`==`RdAddrX`, `DatX` = `WrDat` in the same cycle, ahead of the edge.
  - Applies independently to each port.
  - Gated off while `Reset`=0.
- Flags: at rising edge, if `Reset`=1 and `FlagEn`=1, {`ZeroQ`,`ParQ`,`SCoQ`} <= {`ZeroIn`,`ParIn`,`SCoIn`}. Otherwise flags hold.
  - Flag capture is independent of `WrEn`, so compare ops can update flags without a register write.
- Reset:
  - Every register and all three flags clear to 0 at the first rising edge with `Reset`=0.
  - Reset dominates a concurrent `WrEn`/`FlagEn`; the write is dropped, not deferred.
- Out-of-range addresses: impossible by construction, since depth is exactly 2**A.

## Timing
- Read latency: 0 cycles, combinational from address to data.
- Write latency: 1 edge. Written data is visible on a non-bypassed read in the cycle after the edge; with `BYPASS`=1 it is also visible in the same cycle.
- Flag latency: 1 edge; `ZeroQ`/`ParQ`/`SCoQ` reflect captured values immediately after the edge.
- Reset values after the reset edge:
  - all registers = 0, so `DatA`=`DatB`=0 for any address;
  - `ZeroQ`=`ParQ`=`SCoQ`=0.
  - Before the first reset edge, outputs are undefined.
- Reset mid-operation: a write pending in the reset cycle is lost. Normal operation resumes at the first edge with `Reset`=1.
- No combinational path from `FlagEn` or any `*In` flag input to `DatA`/`DatB`.
- Loop constraint: the path `WrDat`→`DatA`/`DatB` exists when `BYPASS`=1. Integration must not route ALU `Rslt` back to `WrDat` in the same cycle as a bypassed read to the same address.

## Test plan
- Reset: write 8'hFF to all 8 registers, assert `Reset`=0 for 1 edge → every address reads 8'h00; flags = 000.
- Write/read: write 8'h5A to R3 and 8'hA5 to R6, then `RdAddrA`=3, `RdAddrB`=6 → `DatA`=8'h5A, `DatB`=8'hA5. Set `RdAddrA`=`RdAddrB`=3 → both 8'h5A.
- Bypass: R2=8'h11; in one cycle `WrEn`=1, `WrAddr`=2, `WrDat`=8'h22, `RdAddrA`=2 → `DatA`=8'h22 before the edge with `BYPASS`=1, 8'h11 with `BYPASS`=0. Both configurations read 8'h22 after the edge.
- Reset priority: R1=8'h33; drive `Reset`=0 together with `WrEn`=1, `WrAddr`=1, `WrDat`=8'h44 → R1=8'h00 after the edge. No 8'h44 appears on `DatA` during reset, even with `BYPASS`=1.
- Flags: `FlagEn`=1 with {`ZeroIn`,`ParIn`,`SCoIn`}=101 → `ZeroQ`=1, `ParQ`=0, `SCoQ`=1. Then `FlagEn`=0 with inputs 010 for 3 cycles → flags hold at 101.
- Flag/write independence: `FlagEn`=1, `WrEn`=0, inputs 011 → flags = 011 and all registers unchanged. `WrEn`=1 to R7 with `FlagEn`=0 → flags unchanged.
